// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline constants and the fetch-packet layout.
package riscv_pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int PRED_W = 2;

    // Packed storage order, MSB first.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            pred_valid;
        logic            pred_taken;
        logic [XLEN-1:0] predicted_pc;
    } fetch_pkt_t;

    function automatic int pkt_w(input int xlen);
        return 3 * xlen + PRED_W;
    endfunction
endpackage

// File: rtl/pipe_fifo_mem.sv
// pipe_fifo_mem: DEPTH-entry register array with one write port and an async read port.
module pipe_fifo_mem #(
    parameter int W     = 98,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order IF->ID packet queue with flush and prediction sanitising.
module if_id_queue
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = riscv_pipe_pkg::XLEN,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipeline_flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_instruction,
    input  logic             if_pred_valid,
    input  logic             if_pred_taken,
    input  logic [XLEN-1:0]  if_predicted_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_instruction,
    output logic             id_pred_valid,
    output logic             id_pred_taken,
    output logic [XLEN-1:0]  id_predicted_pc,
    output logic [CNT_W-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = pkt_w(XLEN);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [W-1:0]  wdata, rdata;

    assign if_ready = occupancy != CNT_W'(DEPTH);
    assign id_valid = occupancy != '0;
    assign push     = if_valid & if_ready & ~pipeline_flush;
    assign pop      = id_valid & id_ready & ~pipeline_flush;

    // Prediction fields are zeroed on entry when the BTB missed.
    assign wdata = {if_pc, if_instruction, if_pred_valid, if_pred_valid & if_pred_taken,
                    if_pred_valid ? if_predicted_pc : {XLEN{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst || pipeline_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    pipe_fifo_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign id_pc           = id_valid ? rdata[3*XLEN+1 -: XLEN] : '0;
    assign id_instruction  = id_valid ? rdata[2*XLEN+1 -: XLEN] : XLEN'(NOP_INSTR);
    assign id_pred_valid   = id_valid & rdata[XLEN+1];
    assign id_pred_taken   = id_valid & rdata[XLEN];
    assign id_predicted_pc = id_valid ? rdata[XLEN-1:0] : '0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed checks of the IF->ID queue at DEPTH=2 and DEPTH=4.
module tb_if_id_queue;
    logic        clk = 0;
    logic        rst, pipeline_flush, if_valid, id_ready;
    logic        if_pred_valid, if_pred_taken;
    logic [31:0] if_pc, if_instruction, if_predicted_pc;

    logic        if_ready, id_valid, id_pred_valid, id_pred_taken;
    logic [31:0] id_pc, id_instruction, id_predicted_pc;
    logic [1:0]  occupancy;

    logic        if_ready4, id_valid4, id_pred_valid4, id_pred_taken4;
    logic [31:0] id_pc4, id_instruction4, id_predicted_pc4;
    logic [2:0]  occupancy4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_id_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pipeline_flush(pipeline_flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instruction(if_instruction), .if_pred_valid(if_pred_valid),
        .if_pred_taken(if_pred_taken), .if_predicted_pc(if_predicted_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_instruction(id_instruction), .id_pred_valid(id_pred_valid),
        .id_pred_taken(id_pred_taken), .id_predicted_pc(id_predicted_pc),
        .occupancy(occupancy)
    );

    if_id_queue #(.XLEN(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .pipeline_flush(pipeline_flush),
        .if_valid(if_valid), .if_ready(if_ready4), .if_pc(if_pc),
        .if_instruction(if_instruction), .if_pred_valid(if_pred_valid),
        .if_pred_taken(if_pred_taken), .if_predicted_pc(if_predicted_pc),
        .id_valid(id_valid4), .id_ready(id_ready), .id_pc(id_pc4),
        .id_instruction(id_instruction4), .id_pred_valid(id_pred_valid4),
        .id_pred_taken(id_pred_taken4), .id_predicted_pc(id_predicted_pc4),
        .occupancy(occupancy4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        if_valid       = v;
        if_pc          = pc;
        if_instruction = ~pc;
    endtask

    task automatic test_reset();
        rst = 1; pipeline_flush = 0; id_ready = 0;
        if_pred_valid = 0; if_pred_taken = 0; if_predicted_pc = 0;
        drive(1, 32'h55);
        step(); step();
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        n_cmp++; if (id_instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_nop got %h want 00000013", id_instruction); end
        n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
        n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        rst = 0;
        drive(0, 0);
    endtask

    task automatic test_fill();
        id_ready = 0;
        drive(1, 32'h0); step();
        n_cmp++; if (occupancy !== 2'd1 || id_valid !== 1'b1) begin n_fail++; $display("FAIL fill_first occ %0d valid %b want 1 1", occupancy, id_valid); end
        n_cmp++; if (id_instruction !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fill_instr got %h want ffffffff", id_instruction); end
        drive(1, 32'h4); step();
        n_cmp++; if (occupancy !== 2'd2 || if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full occ %0d if_ready %b want 2 0", occupancy, if_ready); end
        n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head got %h want 0", id_pc); end
        drive(1, 32'h8); step();
        n_cmp++; if (occupancy !== 2'd2 || id_pc !== 32'h0) begin n_fail++; $display("FAIL fill_hold occ %0d pc %h want 2 0", occupancy, id_pc); end
        id_ready = 1; step();
        n_cmp++; if (occupancy !== 2'd1 || id_pc !== 32'h4) begin n_fail++; $display("FAIL fill_pop1 occ %0d pc %h want 1 4", occupancy, id_pc); end
        step();
        n_cmp++; if (occupancy !== 2'd1 || id_pc !== 32'h8) begin n_fail++; $display("FAIL fill_pop2 occ %0d pc %h want 1 8", occupancy, id_pc); end
        n_cmp++; if (id_instruction !== ~32'h8) begin n_fail++; $display("FAIL fill_instr8 got %h want %h", id_instruction, ~32'h8); end
        drive(0, 0); step();
        n_cmp++; if (id_valid !== 1'b0 || id_instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL fill_drain valid %b instr %h want 0 00000013", id_valid, id_instruction); end
    endtask

    task automatic test_streaming();
        id_ready = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + 32'(4 * i)); step();
            n_cmp++; if (occupancy !== 2'd1 || id_pc !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_%0d occ %0d pc %h want 1 %h", i, occupancy, id_pc, 32'h100 + 32'(4 * i)); end
        end
        drive(0, 0); step();
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain occ %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        id_ready = 0;
        drive(1, 32'h30); step();
        drive(1, 32'h34); step();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre occ %0d want 2", occupancy); end
        pipeline_flush = 1; id_ready = 1;
        drive(1, 32'h40); step();
        n_cmp++; if (occupancy !== 2'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty occ %0d valid %b want 0 0", occupancy, id_valid); end
        pipeline_flush = 0;
        drive(0, 0); step();
        n_cmp++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL flush_no40 valid %b pc %h want 0 0", id_valid, id_pc); end
        id_ready = 0;
        drive(1, 32'h50); step();
        n_cmp++; if (occupancy !== 2'd1 || id_pc !== 32'h50) begin n_fail++; $display("FAIL flush_after occ %0d pc %h want 1 50", occupancy, id_pc); end
        drive(0, 0); id_ready = 1; step();
    endtask

    task automatic test_sanitise();
        id_ready = 0;
        if_pred_valid = 0; if_pred_taken = 1; if_predicted_pc = 32'hDEAD_BEEC;
        drive(1, 32'h60); step();
        n_cmp++; if (id_pred_taken !== 1'b0 || id_predicted_pc !== 32'h0 || id_pred_valid !== 1'b0) begin n_fail++; $display("FAIL sanitise_zero taken %b ppc %h want 0 0", id_pred_taken, id_predicted_pc); end
        id_ready = 1;
        if_pred_valid = 1; if_pred_taken = 1; if_predicted_pc = 32'h0000_2000;
        drive(1, 32'h64); step();
        n_cmp++; if (id_pc !== 32'h64 || id_pred_valid !== 1'b1 || id_pred_taken !== 1'b1 || id_predicted_pc !== 32'h2000) begin n_fail++; $display("FAIL sanitise_pass pc %h pv %b pt %b ppc %h want 64 1 1 2000", id_pc, id_pred_valid, id_pred_taken, id_predicted_pc); end
        if_pred_valid = 0; if_pred_taken = 0; if_predicted_pc = 0;
        drive(0, 0); step();
    endtask

    task automatic test_depth4();
        rst = 1; step(); rst = 0;
        id_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 32'(4 * i)); step();
            if (i == 2) begin
                n_cmp++; if (if_ready4 !== 1'b1 || occupancy4 !== 3'd3) begin n_fail++; $display("FAIL d4_three if_ready %b occ %0d want 1 3", if_ready4, occupancy4); end
            end
        end
        n_cmp++; if (if_ready4 !== 1'b0 || occupancy4 !== 3'd4) begin n_fail++; $display("FAIL d4_full if_ready %b occ %0d want 0 4", if_ready4, occupancy4); end
        n_cmp++; if (id_pc4 !== 32'h200) begin n_fail++; $display("FAIL d4_head got %h want 200", id_pc4); end
        rst = 1; step(); rst = 0;
        drive(0, 0);
        n_cmp++; if (occupancy4 !== 3'd0 || id_valid4 !== 1'b0 || if_ready4 !== 1'b1) begin n_fail++; $display("FAIL d4_reset occ %0d valid %b if_ready %b want 0 0 1", occupancy4, id_valid4, if_ready4); end
        step();
        n_cmp++; if (id_valid4 !== 1'b0 || id_instruction4 !== 32'h0000_0013) begin n_fail++; $display("FAIL d4_stays_empty valid %b instr %h want 0 00000013", id_valid4, id_instruction4); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_flush();
        test_sanitise();
        test_depth4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
